// File: rtl/logic32_serial_if.sv
// Start/busy/done handshake and operand/result bus for the nibble-serial logic unit.
interface logic32_serial_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out;
  logic             zero;

  modport master (
    output start, op, a, b,
    input  busy, done, out, zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, out, zero
  );
endinterface

// File: rtl/logic32_serial.sv
// Nibble-serial logic unit: one SLICE-bit slice reused over WIDTH/SLICE cycles.
// Ops: 00 AND, 01 OR, 10 XOR, 11 NOR. out/zero update only on completion.
module logic32_serial #(
  parameter int WIDTH = 32,
  parameter int SLICE = 4
) (
  input logic              clk,
  input logic              rst_n,
  logic32_serial_if.slave  bus
);
  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             zero_q, zero_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [SLICE-1:0] a_nib, b_nib, r_nib;
  logic [WIDTH-1:0] acc_next;

  // One slice of the selected logic op on the current nibble, merged into the accumulator.
  always_comb begin
    a_nib = a_q[int'(idx_q) * SLICE +: SLICE];
    b_nib = b_q[int'(idx_q) * SLICE +: SLICE];
    case (op_q)
      2'b00:   r_nib = a_nib & b_nib;
      2'b01:   r_nib = a_nib | b_nib;
      2'b10:   r_nib = a_nib ^ b_nib;
      default: r_nib = ~(a_nib | b_nib);
    endcase
    acc_next = acc_q;
    acc_next[int'(idx_q) * SLICE +: SLICE] = r_nib;
  end

  // Next-state and registered-output logic for the IDLE/RUN/DONE sequence.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    out_d   = out_q;
    zero_d  = zero_q;
    busy_d  = busy_q;
    done_d  = done_q;
    case (state_q)
      // DONE accepts a new request exactly like IDLE so operations can run back-to-back.
      IDLE, DONE: begin
        done_d = 1'b0;
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          op_d    = bus.op;
          acc_d   = '0;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end else begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      RUN: begin
        acc_d = acc_next;
        if (idx_q == LAST_IDX) begin
          // Publish the full result including the final nibble computed this cycle.
          out_d   = acc_next;
          zero_d  = (acc_next == '0);
          done_d  = 1'b1;
          busy_d  = 1'b0;
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      default: begin
        busy_d  = 1'b0;
        done_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State register with asynchronous abort to reset values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      out_q   <= '0;
      zero_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      out_q   <= out_d;
      zero_q  <= zero_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.out  = out_q;
  assign bus.zero = zero_q;
endmodule

// File: tb/tb_logic32_serial.sv
// Directed and randomized bench for logic32_serial against a whole-word reference model.
module tb_logic32_serial;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic32_serial_if #(.WIDTH(32)) bus ();

  logic32_serial #(.WIDTH(32), .SLICE(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          total = 0;
  int          bad   = 0;
  logic [31:0] held_out;

  // Whole-word reference: each op is a plain bitwise expression.
  function automatic logic [31:0] ref_op(logic [1:0] op, logic [31:0] a, logic [31:0] b);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~(a | b);
    endcase
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a request for one edge; returns just after the accepting edge.
  task automatic launch(logic [1:0] op, logic [31:0] a, logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
    bus.op    = 2'($urandom_range(3));
  endtask

  // Eight busy cycles with out held, then the done cycle with the expected result.
  // scramble: pulse start and change operands during RUN (must be ignored).
  task automatic wait_result(string tag, logic [31:0] exp, bit scramble);
    for (int i = 0; i < 8; i++) begin
      chk({tag, "_busy"}, {30'b0, bus.busy, bus.done}, 32'h2);
      chk({tag, "_hold"}, bus.out, held_out);
      if (scramble) begin
        bus.start = (i < 7);
        bus.a     = $urandom;
        bus.b     = $urandom;
        bus.op    = 2'($urandom_range(3));
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    chk({tag, "_done"}, {30'b0, bus.busy, bus.done}, 32'h1);
    chk({tag, "_out"}, bus.out, exp);
    chk({tag, "_zero"}, {31'b0, bus.zero}, {31'b0, exp == 32'h0});
    held_out = exp;
  endtask

  task automatic post_idle(string tag);
    @(negedge clk);
    chk({tag, "_idle"}, {30'b0, bus.busy, bus.done}, 32'h0);
    chk({tag, "_keep"}, bus.out, held_out);
  endtask

  task automatic run_op(string tag, logic [1:0] op, logic [31:0] a, logic [31:0] b);
    launch(op, a, b);
    wait_result(tag, ref_op(op, a, b), 1'b0);
    post_idle(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  rop, rop2;
    logic [31:0] ra, rb, ra2, rb2;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a     = '0;
    bus.b     = '0;
    held_out  = '0;
    repeat (2) @(negedge clk);
    chk("rst_out", bus.out, 32'h0);
    chk("rst_zero", {31'b0, bus.zero}, 32'h1);
    chk("rst_bd", {30'b0, bus.busy, bus.done}, 32'h0);
    rst_n = 1'b1;

    run_op("and", 2'b00, 32'hF0F0_1234, 32'hFF00_FFFF);
    chk("and_const", held_out, 32'hF000_1234);
    run_op("or",  2'b01, 32'hAAAA_5555, 32'h0F0F_0F0F);
    chk("or_const", held_out, 32'hAFAF_5F5F);
    run_op("xor", 2'b10, 32'hAAAA_5555, 32'h0F0F_0F0F);
    chk("xor_const", held_out, 32'hA5A5_5A5A);
    run_op("nor", 2'b11, 32'hAAAA_5555, 32'h0F0F_0F0F);
    chk("nor_const", held_out, 32'h5050_A0A0);
    run_op("zand", 2'b00, 32'hAAAA_AAAA, 32'h5555_5555);
    run_op("zxor", 2'b10, 32'hAAAA_AAAA, 32'h5555_5555);
    chk("zxor_const", held_out, 32'hFFFF_FFFF);

    for (int n = 0; n < 12; n++) begin
      rop = 2'($urandom_range(3));
      run_op("rnd", rop, $urandom, $urandom);
    end

    // Busy-ignore: start pulses and operand changes during RUN are ignored.
    ra = $urandom;
    rb = $urandom;
    launch(2'b01, ra, rb);
    wait_result("ign", ra | rb, 1'b1);
    post_idle("ign");

    // Back-to-back: start held through the DONE cycle with new operands.
    ra  = $urandom; rb  = $urandom; rop  = 2'($urandom_range(3));
    ra2 = $urandom; rb2 = $urandom; rop2 = 2'($urandom_range(3));
    launch(rop, ra, rb);
    for (int i = 0; i < 8; i++) begin
      chk("b2b1_busy", {30'b0, bus.busy, bus.done}, 32'h2);
      if (i == 7) begin
        bus.start = 1'b1;
        bus.op    = rop2;
        bus.a     = ra2;
        bus.b     = rb2;
      end
      @(negedge clk);
    end
    chk("b2b1_done", {30'b0, bus.busy, bus.done}, 32'h1);
    chk("b2b1_out", bus.out, ref_op(rop, ra, rb));
    held_out = ref_op(rop, ra, rb);
    @(negedge clk);
    bus.start = 1'b0;
    wait_result("b2b2", ref_op(rop2, ra2, rb2), 1'b0);
    post_idle("b2b2");

    // Asynchronous reset at cycle 4 of RUN aborts without a done pulse.
    launch(2'b10, 32'h1234_5678, 32'h8765_4321);
    repeat (3) @(negedge clk);
    chk("mid_busy_pre", {31'b0, bus.busy}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_out", bus.out, 32'h0);
    chk("mid_zero", {31'b0, bus.zero}, 32'h1);
    chk("mid_bd", {30'b0, bus.busy, bus.done}, 32'h0);
    held_out = '0;
    @(negedge clk);
    chk("mid_hold_bd", {30'b0, bus.busy, bus.done}, 32'h0);
    rst_n = 1'b1;
    post_idle("mid_after");
    post_idle("mid_after2");
    ra = $urandom;
    rb = $urandom;
    run_op("mid_fresh", 2'b11, ra, rb);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
